fetch_line_req: RTL and testbench

FETCH_LINE_REQ -- requirements
Module: fetch_line_req

---
 rtl/fetch_line_req.sv | 128 ++++++++++++
 tb/tb_fetch_line_req.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_line_req.sv
// Instruction-line fetch requester: issues one 64-byte line read at a time from fetch_pc,
// delivers the returned line to the instruction buffer and follows pipeline redirects.
module fetch_line_req #(
    parameter logic [47:0] RESET_PC = 48'h0000_8000_0000
) (
    input  logic         clock,
    input  logic         reset_n,
    input  logic         fetch_inst,
    input  logic         redirect_valid,
    input  logic [47:0]  redirect_target,
    output logic         mem_req_valid,
    output logic [47:0]  mem_req_addr,
    input  logic         mem_req_ready,
    input  logic         mem_resp_valid,
    input  logic [511:0] mem_resp_data,
    output logic         pc_operation_done,
    output logic [511:0] pc_read_inst,
    output logic [47:0]  pc,
    output logic         cut_first_32_bit,
    output logic         clear_ibuffer,
    output logic         can_fetch_inst,
    output logic [1:0]   fsm_state
);

    // Handshake: a request transfers on a rising edge where mem_req_valid and
    // mem_req_ready are both high; mem_req_addr is held stable while valid waits.
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_WAIT = 2'd2;
    localparam logic [1:0] ST_DROP = 2'd3;

    logic [1:0]   state_q, state_d;
    logic [47:0]  fetch_pc_q, fetch_pc_d;
    logic         pending_q, pending_d;
    logic         done_q, done_d;
    logic         clear_q, clear_d;
    logic [511:0] line_q, line_d;
    logic [47:0]  pc_q, pc_d;
    logic         cut_q, cut_d;
    logic [47:0]  next_line_pc;

    // A line starting at word 1 of a 64-byte block only has 15 words before the boundary.
    assign next_line_pc = fetch_pc_q + (fetch_pc_q[2] ? 48'd60 : 48'd64);

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        pending_d  = pending_q;
        done_d     = 1'b0;
        clear_d    = 1'b0;
        line_d     = line_q;
        pc_d       = pc_q;
        cut_d      = cut_q;

        if (redirect_valid) begin
            fetch_pc_d = {redirect_target[47:2], 2'b00};
            pending_d  = 1'b0;
            clear_d    = 1'b1;
            case (state_q)
                ST_WAIT: state_d = mem_resp_valid ? ST_REQ : ST_DROP;
                ST_DROP: state_d = ST_DROP;
                default: state_d = ST_REQ;
            endcase
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (fetch_inst || pending_q) begin
                        state_d   = ST_REQ;
                        pending_d = 1'b0;
                    end
                end
                ST_REQ: begin
                    if (fetch_inst) pending_d = 1'b1;
                    if (mem_req_ready) state_d = ST_WAIT;
                end
                ST_WAIT: begin
                    if (fetch_inst) pending_d = 1'b1;
                    if (mem_resp_valid) begin
                        done_d     = 1'b1;
                        line_d     = mem_resp_data;
                        pc_d       = fetch_pc_q;
                        cut_d      = fetch_pc_q[2];
                        fetch_pc_d = next_line_pc;
                        state_d    = ST_IDLE;
                    end
                end
                default: begin
                    if (fetch_inst) pending_d = 1'b1;
                    if (mem_resp_valid) state_d = ST_REQ;
                end
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_REQ;
            fetch_pc_q <= RESET_PC;
            pending_q  <= 1'b0;
            done_q     <= 1'b0;
            clear_q    <= 1'b0;
            line_q     <= '0;
            pc_q       <= '0;
            cut_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            pending_q  <= pending_d;
            done_q     <= done_d;
            clear_q    <= clear_d;
            line_q     <= line_d;
            pc_q       <= pc_d;
            cut_q      <= cut_d;
        end
    end

    // Reset parks the FSM in REQ, so the request is masked until reset_n is released.
    assign mem_req_valid     = (state_q == ST_REQ) && reset_n;
    assign mem_req_addr      = fetch_pc_q;
    assign pc_operation_done = done_q;
    assign clear_ibuffer     = clear_q;
    assign pc_read_inst      = line_q;
    assign pc                = pc_q;
    assign cut_first_32_bit  = cut_q;
    assign can_fetch_inst    = (state_q == ST_IDLE) && !pending_q;
    assign fsm_state         = state_q;

endmodule

// File: tb/tb_fetch_line_req.sv
// Directed bench for fetch_line_req: line fetch, delivery, redirects, merging of
// refill pulses, address wrap and reset during an outstanding request.
module tb_fetch_line_req;

    logic         clock;
    logic         reset_n;
    logic         fetch_inst;
    logic         redirect_valid;
    logic [47:0]  redirect_target;
    logic         mem_req_valid;
    logic [47:0]  mem_req_addr;
    logic         mem_req_ready;
    logic         mem_resp_valid;
    logic [511:0] mem_resp_data;
    logic         pc_operation_done;
    logic [511:0] pc_read_inst;
    logic [47:0]  pc;
    logic         cut_first_32_bit;
    logic         clear_ibuffer;
    logic         can_fetch_inst;
    logic [1:0]   fsm_state;

    int checks = 0;
    int errors = 0;

    fetch_line_req #(.RESET_PC(48'h8000)) dut (
        .clock            (clock),
        .reset_n          (reset_n),
        .fetch_inst       (fetch_inst),
        .redirect_valid   (redirect_valid),
        .redirect_target  (redirect_target),
        .mem_req_valid    (mem_req_valid),
        .mem_req_addr     (mem_req_addr),
        .mem_req_ready    (mem_req_ready),
        .mem_resp_valid   (mem_resp_valid),
        .mem_resp_data    (mem_resp_data),
        .pc_operation_done(pc_operation_done),
        .pc_read_inst     (pc_read_inst),
        .pc               (pc),
        .cut_first_32_bit (cut_first_32_bit),
        .clear_ibuffer    (clear_ibuffer),
        .can_fetch_inst   (can_fetch_inst),
        .fsm_state        (fsm_state)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // All driving and sampling happens at the falling edge.
    task automatic accept_req(input string tag, input logic [47:0] exp_addr);
        int n;
        n = 0;
        while (!mem_req_valid && n < 16) begin
            @(negedge clock);
            n++;
        end
        check({tag, "_valid"}, mem_req_valid, 1'b1);
        check({tag, "_addr"}, mem_req_addr, exp_addr);
        mem_req_ready = 1'b1;
        @(negedge clock);
        mem_req_ready = 1'b0;
    endtask

    task automatic respond(input logic [511:0] data);
        mem_resp_valid = 1'b1;
        mem_resp_data  = data;
        @(negedge clock);
        mem_resp_valid = 1'b0;
        mem_resp_data  = '0;
    endtask

    task automatic pulse_fetch();
        fetch_inst = 1'b1;
        @(negedge clock);
        fetch_inst = 1'b0;
    endtask

    task automatic do_redirect(input logic [47:0] target);
        redirect_valid  = 1'b1;
        redirect_target = target;
        @(negedge clock);
        redirect_valid  = 1'b0;
        redirect_target = '0;
    endtask

    task automatic check_delivery(input string tag, input logic [47:0] exp_pc,
                                  input logic exp_cut, input logic [511:0] exp_line);
        check({tag, "_done"}, pc_operation_done, 1'b1);
        check({tag, "_pc"}, pc, exp_pc);
        check({tag, "_cut"}, cut_first_32_bit, exp_cut);
        check({tag, "_line"}, pc_read_inst, exp_line);
        check({tag, "_noclr"}, clear_ibuffer, 1'b0);
    endtask

    logic [511:0] d [0:11];

    initial begin
        int reqs;
        for (int i = 0; i < 12; i++) begin
            for (int w = 0; w < 16; w++) d[i][w*32 +: 32] = $urandom_range(32'h7fff_ffff, 0);
        end

        reset_n = 1'b0; fetch_inst = 1'b0; redirect_valid = 1'b0; redirect_target = '0;
        mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_data = '0;
        repeat (3) @(negedge clock);
        check("rst_req_valid", mem_req_valid, 1'b0);
        check("rst_done", pc_operation_done, 1'b0);
        check("rst_clear", clear_ibuffer, 1'b0);
        check("rst_line", pc_read_inst, '0);
        check("rst_pc", pc, '0);
        check("rst_cut", cut_first_32_bit, 1'b0);
        check("rst_can_fetch", can_fetch_inst, 1'b0);
        reset_n = 1'b1;

        // Self-start at reset PC, then sequential line after a refill pulse.
        accept_req("boot", 48'h8000);
        check("wait_can_fetch", can_fetch_inst, 1'b0);
        repeat (2) @(negedge clock);
        respond(d[0]);
        check_delivery("boot_dlv", 48'h8000, 1'b0, d[0]);
        check("boot_can_fetch", can_fetch_inst, 1'b1);
        check("boot_idle_noreq", mem_req_valid, 1'b0);
        @(negedge clock);
        check("done_one_cycle", pc_operation_done, 1'b0);
        check("line_hold", pc_read_inst, d[0]);
        check("idle_waits_fetch", mem_req_valid, 1'b0);
        pulse_fetch();
        accept_req("seq", 48'h8040);
        respond(d[1]);
        check_delivery("seq_dlv", 48'h8040, 1'b0, d[1]);

        // Redirect from IDLE to an odd word: 15-word line, then +60.
        do_redirect(48'h1004);
        check("rdi_clear", clear_ibuffer, 1'b1);
        check("rdi_nodone", pc_operation_done, 1'b0);
        accept_req("rdi", 48'h1004);
        check("clear_one_cycle", clear_ibuffer, 1'b0);
        respond(d[2]);
        check_delivery("rdi_dlv", 48'h1004, 1'b1, d[2]);
        pulse_fetch();
        accept_req("plus60", 48'h1040);

        // Redirect in WAIT (low bits ignored): the late response is dropped.
        do_redirect(48'h2003);
        check("rdw_clear", clear_ibuffer, 1'b1);
        check("rdw_noreq", mem_req_valid, 1'b0);
        @(negedge clock);
        respond(d[3]);
        check("drop_nodone", pc_operation_done, 1'b0);
        check("drop_pc_hold", pc, 48'h1004);
        accept_req("after_drop", 48'h2000);
        respond(d[4]);
        check_delivery("rdw_dlv", 48'h2000, 1'b0, d[4]);

        // Redirect coinciding with the response.
        pulse_fetch();
        accept_req("pre_coin", 48'h2040);
        redirect_valid = 1'b1; redirect_target = 48'h3000;
        mem_resp_valid = 1'b1; mem_resp_data = d[5];
        @(negedge clock);
        redirect_valid = 1'b0; mem_resp_valid = 1'b0;
        check("coin_nodone", pc_operation_done, 1'b0);
        check("coin_clear", clear_ibuffer, 1'b1);
        check("coin_line_hold", pc_read_inst, d[4]);
        accept_req("coin", 48'h3000);
        respond(d[6]);
        check_delivery("coin_dlv", 48'h3000, 1'b0, d[6]);

        // Two refill pulses during WAIT merge into one further request.
        pulse_fetch();
        accept_req("merge0", 48'h3040);
        pulse_fetch();
        check("merge_cf1", can_fetch_inst, 1'b0);
        @(negedge clock);
        pulse_fetch();
        check("merge_cf2", can_fetch_inst, 1'b0);
        respond(d[7]);
        check_delivery("merge_dlv0", 48'h3040, 1'b0, d[7]);
        check("merge_cf3", can_fetch_inst, 1'b0);
        accept_req("merge1", 48'h3080);
        respond(d[8]);
        check_delivery("merge_dlv1", 48'h3080, 1'b0, d[8]);
        check("merge_cf4", can_fetch_inst, 1'b1);
        reqs = 0;
        repeat (4) begin
            @(negedge clock);
            if (mem_req_valid) reqs++;
        end
        check("merge_no_extra", reqs, 0);

        // 48-bit wrap.
        do_redirect(48'hFFFF_FFFF_FFC0);
        accept_req("wrap0", 48'hFFFF_FFFF_FFC0);
        respond(d[9]);
        check_delivery("wrap_dlv", 48'hFFFF_FFFF_FFC0, 1'b0, d[9]);
        pulse_fetch();
        accept_req("wrap1", 48'h0);

        // Redirect beats fetch_inst in WAIT; redirect again while in DROP.
        fetch_inst = 1'b1;
        do_redirect(48'h4000);
        fetch_inst = 1'b0;
        do_redirect(48'h5000);
        check("drop_rd_clear", clear_ibuffer, 1'b1);
        check("drop_rd_noreq", mem_req_valid, 1'b0);
        respond(d[10]);
        check("drop2_nodone", pc_operation_done, 1'b0);
        accept_req("drop_rd", 48'h5000);
        respond(d[11]);
        check_delivery("drop_rd_dlv", 48'h5000, 1'b0, d[11]);
        check("prio_pending_clr", can_fetch_inst, 1'b1);

        // Reset while a request is outstanding.
        pulse_fetch();
        accept_req("pre_rst", 48'h5040);
        reset_n = 1'b0;
        @(negedge clock);
        check("mid_rst_pc", pc, '0);
        check("mid_rst_valid", mem_req_valid, 1'b0);
        reset_n = 1'b1;
        accept_req("post_rst", 48'h8000);
        respond(d[0]);
        check_delivery("post_rst_dlv", 48'h8000, 1'b0, d[0]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
